// File: rtl/exec_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : exec_dispatch
//  Description : Execute-stage dispatcher. Routes decoded instructions to one
//                of NUM_UNITS functional units and returns unit results in
//                issue order through a back-pressured output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_dispatch #(
    parameter  int NUM_UNITS = 4,
    parameter  int DEPTH     = 4,
    parameter  int DATA_W    = 64,
    parameter  int RES_W     = 64,
    localparam int UNIT_W    = $clog2(NUM_UNITS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [UNIT_W-1:0]          in_unit,
    input  logic [DATA_W-1:0]          in_data,
    output logic [NUM_UNITS-1:0]       req_valid,
    input  logic [NUM_UNITS-1:0]       req_ready,
    output logic [DATA_W-1:0]          req_data,
    input  logic [NUM_UNITS-1:0]       resp_valid,
    output logic [NUM_UNITS-1:0]       resp_ready,
    input  logic [NUM_UNITS*RES_W-1:0] resp_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [RES_W-1:0]           res_data,
    output logic [UNIT_W-1:0]          res_unit
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W:0]  c_depth     = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]  c_cnt_one   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
    localparam logic [UNIT_W:0] c_num_units = (UNIT_W+1)'(NUM_UNITS);

    logic [UNIT_W-1:0] r_queue [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_out_v;
    logic [RES_W-1:0]  r_res_data;
    logic [UNIT_W-1:0] r_res_unit;

    logic [UNIT_W-1:0] w_unit;
    logic [UNIT_W-1:0] w_head;
    logic [RES_W-1:0]  w_head_data;
    logic              w_not_full;
    logic              w_nonempty;
    logic              w_gate;
    logic              w_out_free;
    logic              w_can_take;
    logic              w_fire;
    logic              w_take;

    // Out-of-range unit indices fall back to the misc/invalid handler.
    assign w_unit     = ({1'b0, in_unit} < c_num_units) ? in_unit : '0;
    assign w_head     = r_queue[r_rd_ptr];
    assign w_not_full = (r_count != c_depth);
    assign w_nonempty = (r_count != '0);

    // While reset is asserted every handshake output is forced low.
    assign w_gate     = rst && !flush;
    assign w_out_free = !r_out_v || res_ready;

    assign in_ready   = req_ready[w_unit] && w_not_full && w_gate;
    assign w_fire     = in_valid && in_ready;
    assign w_can_take = w_nonempty && w_out_free && w_gate;
    assign w_take     = w_can_take && resp_valid[w_head];

    assign req_data   = in_data;
    assign res_valid  = r_out_v;
    assign res_data   = r_res_data;
    assign res_unit   = r_res_unit;

    always_comb begin
        req_valid   = '0;
        resp_ready  = '0;
        w_head_data = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_unit == UNIT_W'(i)) begin
                req_valid[i] = in_valid && w_not_full && w_gate;
            end
            if (w_head == UNIT_W'(i)) begin
                resp_ready[i] = w_can_take;
                w_head_data   = resp_data[i*RES_W +: RES_W];
            end
        end
    end

    // Queue storage needs no reset: entries are only read while count > 0.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_queue[r_wr_ptr] <= w_unit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_v    <= 1'b0;
            r_res_data <= '0;
            r_res_unit <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_out_v  <= 1'b0;
        end else begin
            if (w_fire) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_take) begin
                r_rd_ptr   <= r_rd_ptr + c_ptr_one;
                r_out_v    <= 1'b1;
                r_res_data <= w_head_data;
                r_res_unit <= w_head;
            end else if (r_out_v && res_ready) begin
                r_out_v <= 1'b0;
            end
            if (w_fire && !w_take) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_take && !w_fire) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_dispatch
//  Description : Directed self-checking bench for exec_dispatch; the bench
//                itself plays the role of every functional unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_dispatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic flush;

    // Four-unit instance with default widths.
    logic         a_in_valid, a_in_ready;
    logic [1:0]   a_in_unit;
    logic [63:0]  a_in_data, a_req_data;
    logic [3:0]   a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
    logic [255:0] a_resp_data;
    logic         a_res_valid, a_res_ready;
    logic [63:0]  a_res_data;
    logic [1:0]   a_res_unit;

    // Three-unit instance for the out-of-range index and wrap checks.
    logic         b_in_valid, b_in_ready;
    logic [1:0]   b_in_unit;
    logic [15:0]  b_in_data, b_req_data;
    logic [2:0]   b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
    logic [47:0]  b_resp_data;
    logic         b_res_valid, b_res_ready;
    logic [15:0]  b_res_data;
    logic [1:0]   b_res_unit;

    exec_dispatch dut_a (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_unit    (a_in_unit),
        .in_data    (a_in_data),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_data   (a_req_data),
        .resp_valid (a_resp_valid),
        .resp_ready (a_resp_ready),
        .resp_data  (a_resp_data),
        .res_valid  (a_res_valid),
        .res_ready  (a_res_ready),
        .res_data   (a_res_data),
        .res_unit   (a_res_unit)
    );

    exec_dispatch #(
        .NUM_UNITS (3),
        .DEPTH     (4),
        .DATA_W    (16),
        .RES_W     (16)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_unit    (b_in_unit),
        .in_data    (b_in_data),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_data   (b_req_data),
        .resp_valid (b_resp_valid),
        .resp_ready (b_resp_ready),
        .resp_data  (b_resp_data),
        .res_valid  (b_res_valid),
        .res_ready  (b_res_ready),
        .res_data   (b_res_data),
        .res_unit   (b_res_unit)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pu;

    initial begin
        rst          = 1'b0;
        flush        = 1'b0;
        a_in_valid   = 1'b1;
        a_in_unit    = 2'd2;
        a_in_data    = '0;
        a_req_ready  = 4'hF;
        a_resp_valid = '0;
        a_resp_data  = '0;
        a_res_ready  = 1'b1;
        b_in_valid   = 1'b0;
        b_in_unit    = '0;
        b_in_data    = '0;
        b_req_ready  = 3'b111;
        b_resp_valid = '0;
        b_resp_data  = '0;
        b_res_ready  = 1'b1;

        // Reset state
        #2;
        chk("rst_res_valid", a_res_valid, 0);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_req_valid", a_req_valid, 0);
        chk("rst_res_data", a_res_data, 0);
        a_in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;

        // In-order return: slow unit 2 issued before fast unit 1
        a_in_valid = 1'b1;
        a_in_unit  = 2'd2;
        a_in_data  = 64'hA;
        #1;
        chk("io_req_valid_u2", a_req_valid, 4'b0100);
        chk("io_in_ready", a_in_ready, 1);
        chk("io_req_data", a_req_data, 64'hA);
        tick();
        a_in_unit = 2'd1;
        a_in_data = 64'hB;
        #1;
        chk("io_req_valid_u1", a_req_valid, 4'b0010);
        tick();
        a_in_valid   = 1'b0;
        a_resp_valid = 4'b0010;
        a_resp_data[64 +: 64] = 64'hB;
        #1;
        chk("io_alu_waits", a_resp_ready, 4'b0100);
        tick();
        tick();
        tick();
        chk("io_no_early_result", a_res_valid, 0);
        a_resp_valid = 4'b0110;
        a_resp_data[128 +: 64] = 64'hA;
        #1;
        chk("io_mem_ready", a_resp_ready, 4'b0100);
        tick();
        a_resp_valid = 4'b0010;
        #1;
        chk("io_first_valid", a_res_valid, 1);
        chk("io_first_data", a_res_data, 64'hA);
        chk("io_first_unit", a_res_unit, 2);
        chk("io_alu_ready", a_resp_ready, 4'b0010);
        tick();
        a_resp_valid = '0;
        #1;
        chk("io_second_valid", a_res_valid, 1);
        chk("io_second_data", a_res_data, 64'hB);
        chk("io_second_unit", a_res_unit, 1);
        tick();
        chk("io_drained", a_res_valid, 0);

        // Full queue: unit 3 holds its responses
        a_in_valid = 1'b1;
        a_in_unit  = 2'd3;
        for (int i = 0; i < 4; i++) begin
            a_in_data = 64'h30 + 64'(i);
            tick();
        end
        #1;
        chk("full_in_ready", a_in_ready, 0);
        chk("full_req_valid", a_req_valid, 0);
        a_resp_valid = 4'b1000;
        a_resp_data[192 +: 64] = 64'h30;
        #1;
        chk("full_resp_ready", a_resp_ready, 4'b1000);
        chk("full_same_cycle", a_in_ready, 0);
        tick();
        a_resp_valid = '0;
        #1;
        chk("full_next_in_ready", a_in_ready, 1);
        chk("full_res_data", a_res_data, 64'h30);
        a_in_valid = 1'b0;
        tick();

        // Back-pressure with three entries still queued for unit 3
        a_res_ready  = 1'b0;
        a_resp_valid = 4'b1000;
        a_resp_data[192 +: 64] = 64'h31;
        tick();
        a_resp_data[192 +: 64] = 64'h32;
        #1;
        chk("bp_data0", a_res_data, 64'h31);
        chk("bp_resp_blocked", a_resp_ready, 0);
        tick();
        tick();
        chk("bp_held_data", a_res_data, 64'h31);
        chk("bp_held_valid", a_res_valid, 1);
        chk("bp_held_unit", a_res_unit, 3);
        a_res_ready = 1'b1;
        #1;
        chk("bp_resp_open", a_resp_ready, 4'b1000);
        tick();
        a_resp_data[192 +: 64] = 64'h33;
        #1;
        chk("bp_second", a_res_data, 64'h32);
        tick();
        a_resp_valid = '0;
        #1;
        chk("bp_third", a_res_data, 64'h33);
        tick();
        chk("bp_empty", a_res_valid, 0);
        chk("bp_count0", a_resp_ready, 0);

        // Flush with three in flight and a held result
        a_in_valid = 1'b1;
        a_in_unit  = 2'd1;
        for (int i = 0; i < 4; i++) begin
            a_in_data = 64'h41 + 64'(i);
            tick();
        end
        a_in_valid   = 1'b0;
        a_res_ready  = 1'b0;
        a_resp_valid = 4'b0010;
        a_resp_data[64 +: 64] = 64'h41;
        tick();
        chk("fl_out_v", a_res_valid, 1);
        a_resp_data[64 +: 64] = 64'h42;
        flush       = 1'b1;
        a_in_valid  = 1'b1;
        a_in_unit   = 2'd2;
        a_res_ready = 1'b1;
        #1;
        chk("fl_in_ready", a_in_ready, 0);
        chk("fl_req_valid", a_req_valid, 0);
        chk("fl_resp_ready", a_resp_ready, 0);
        tick();
        flush        = 1'b0;
        a_in_valid   = 1'b0;
        a_resp_valid = '0;
        #1;
        chk("fl_res_valid", a_res_valid, 0);
        chk("fl_count0", a_resp_ready, 0);
        a_in_valid = 1'b1;
        a_in_unit  = 2'd2;
        a_in_data  = 64'h55;
        tick();
        a_in_valid   = 1'b0;
        a_resp_valid = 4'b0100;
        a_resp_data[128 +: 64] = 64'h55;
        #1;
        chk("fl_fresh_head", a_resp_ready, 4'b0100);
        tick();
        a_resp_valid = '0;
        #1;
        chk("fl_fresh_data", a_res_data, 64'h55);
        chk("fl_fresh_unit", a_res_unit, 2);
        tick();

        // Mid-stream reset with count = 3
        a_in_valid = 1'b1;
        a_in_unit  = 2'd1;
        for (int i = 0; i < 4; i++) begin
            a_in_data = 64'h61 + 64'(i);
            tick();
        end
        a_in_valid   = 1'b0;
        a_res_ready  = 1'b0;
        a_resp_valid = 4'b0010;
        a_resp_data[64 +: 64] = 64'h61;
        tick();
        a_resp_valid = '0;
        a_in_valid   = 1'b1;
        a_in_unit    = 2'd2;
        a_in_data    = 64'h77;
        #1;
        chk("mr_pre_valid", a_res_valid, 1);
        rst = 1'b0;
        #1;
        chk("mr_res_valid", a_res_valid, 0);
        chk("mr_in_ready", a_in_ready, 0);
        chk("mr_res_data", a_res_data, 0);
        tick();
        rst         = 1'b1;
        a_res_ready = 1'b1;
        #1;
        chk("mr_in_ready_after", a_in_ready, 1);
        tick();
        a_in_valid   = 1'b0;
        a_resp_valid = 4'b0100;
        a_resp_data[128 +: 64] = 64'h77;
        #1;
        chk("mr_head", a_resp_ready, 4'b0100);
        tick();
        a_resp_valid = '0;
        #1;
        chk("mr_data", a_res_data, 64'h77);
        chk("mr_unit", a_res_unit, 2);

        // Out-of-range index on the three-unit instance
        b_in_valid  = 1'b1;
        b_in_unit   = 2'd3;
        b_in_data   = 16'h00C3;
        b_req_ready = 3'b110;
        #1;
        chk("oor_unit0_busy", b_in_ready, 0);
        b_req_ready = 3'b111;
        #1;
        chk("oor_req_valid", b_req_valid, 3'b001);
        chk("oor_in_ready", b_in_ready, 1);
        tick();
        b_in_valid   = 1'b0;
        b_resp_valid = 3'b001;
        b_resp_data[0 +: 16] = 16'h00C3;
        #1;
        chk("oor_resp_ready", b_resp_ready, 3'b001);
        tick();
        b_resp_valid = '0;
        #1;
        chk("oor_data", b_res_data, 16'h00C3);
        chk("oor_unit", b_res_unit, 0);
        tick();

        // Ten back-to-back single-cycle instructions, pointers wrap twice
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                b_in_valid = 1'b1;
                b_in_unit  = (i % 3 == 0) ? 2'd3 : 2'(i % 3);
                b_in_data  = 16'h100 + 16'(i);
            end else begin
                b_in_valid = 1'b0;
            end
            b_resp_valid = '0;
            if (i > 0) begin
                pu = (i - 1) % 3;
                b_resp_valid[pu] = 1'b1;
                b_resp_data[pu*16 +: 16] = 16'h100 + 16'(i - 1);
            end
            #1;
            if (i < 10) begin
                chk("wrap_in_ready", b_in_ready, 1);
            end
            tick();
            if (i > 0) begin
                chk("wrap_valid", b_res_valid, 1);
                chk("wrap_data", b_res_data, 64'(16'h100 + 16'(i - 1)));
                chk("wrap_unit", b_res_unit, 64'((i - 1) % 3));
            end
        end
        b_resp_valid = '0;
        tick();
        chk("wrap_end", b_res_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_dispatch.md
# exec_dispatch

Parametrised execute-stage dispatcher: routes each decoded instruction to one of NUM_UNITS functional units and returns unit results strictly in issue order. Multiple instructions may be in flight across different units, including multi-cycle units such as mem. The result port supports back-pressure. It sits between the decode stage and writeback, replacing the single-outstanding, unblockable execute arbiter.

## Interface
- NUM_UNITS, 4: number of functional units; must be ≥2. UNIT_W = $clog2(NUM_UNITS) is derived.
- DEPTH, 4: maximum in-flight instructions (order-queue depth); must be a power of two and ≥2.
- DATA_W, 64: width of the decoded-instruction payload.
- RES_W, 64: width of a unit result payload.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; synchronous, single cycle.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  dispatcher accepts the instruction.
- in_unit  in  UNIT_W  target unit index, computed by decode.
- in_data  in  DATA_W  decoded instruction.
- req_valid  out  NUM_UNITS  per-unit request valid.
- req_ready  in  NUM_UNITS  per-unit request ready.
- req_data  out  DATA_W  request payload, shared by all units (equals in_data).
- resp_valid  in  NUM_UNITS  per-unit result valid.
- resp_ready  out  NUM_UNITS  per-unit result accept.
- resp_data  in  NUM_UNITS*RES_W  unit i occupies bits [i*RES_W +: RES_W].
- res_valid  out  1  in-order result valid.
- res_ready  in  1  consumer ready.
- res_data  out  RES_W  result payload.
- res_unit  out  UNIT_W  unit that produced res_data.

## Operation
- **Target unit.** u = in_unit when in_unit < NUM_UNITS; otherwise u = 0. Unit 0 is the misc/invalid handler.
- **Issue.**
  - fire = in_valid && req_ready[u] && count < DEPTH && !flush.
  - in_ready = req_ready[u] && count < DEPTH && !flush.
  - req_valid[u] = in_valid && count < DEPTH && !flush. All other req_valid bits are 0.
  - On fire, u is pushed into the order queue at wr_ptr.
- **Order queue.**
  - Circular buffer of DEPTH unit indices.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
  - Push when full is forbidden, even if a pop occurs in the same cycle; in_ready does not depend on res_ready.
- **Completion.**
  - head = queue[rd_ptr], meaningful only when count > 0.
  - take = count > 0 && resp_valid[head] && (!out_v || res_ready) && !flush.
  - resp_ready[head] = (count > 0) && (!out_v || res_ready) && !flush. All other resp_ready bits are 0.
  - Responses from non-head units wait. The unit holds them under its own valid/ready handshake.
- **Output register.**
  - On take: out_v <= 1, res_data <= resp_data slice of head, res_unit <= head, rd_ptr++, count--.
  - Otherwise, if res_valid && res_ready, out_v <= 0.
  - res_valid = out_v.
- **Simultaneous events.** Push and take in the same cycle leave count unchanged and advance both pointers.
- **Flush.**
  - In a flush cycle: in_ready = 0, all req_valid = 0, all resp_ready = 0.
  - At the next edge, wr_ptr, rd_ptr, count and out_v clear to 0.
  - Units see the same flush and must discard their own in-flight work; the dispatcher does not drain them.
- **Reset (rst = 0).**
  - wr_ptr, rd_ptr, count, out_v are all 0.
  - res_data and res_unit are 0.
  - Outputs are therefore: res_valid = 0, in_ready = 0, req_valid = 0, resp_ready = 0.
  - Queue contents are don't-care.

## Timing
- Issue is combinational pass-through: the instruction reaches the unit in the same cycle it is accepted.
- A unit response accepted at edge t appears on res_valid/res_data after edge t.
- Throughput is one result per cycle while res_ready = 1 and the head unit is valid.
- No combinational path from res_ready to in_ready.
- There is a combinational path from res_ready to resp_ready.
- When res_valid = 1 and res_ready = 0, res_data and res_unit hold stable.

## Test plan
- **Reset.** Drive rst = 0 mid-stream with count = 3 → res_valid = 0 and in_ready = 0 immediately. After release with req_ready = 1, the first issue lands at queue slot 0.
- **In-order return.** Issue unit 2 (mem, 5-cycle latency) with data 0xA, then unit 1 (alu, 1-cycle) with data 0xB. Unit 1 asserts resp_valid first → resp_ready[1] stays 0 until unit 2 completes. Results then emerge as 0xA (res_unit = 2) followed by 0xB (res_unit = 1) on consecutive cycles.
- **Full queue.** Issue 4 instructions to unit 3, which never responds → count = 4 and in_ready = 0 with in_valid = 1. Complete one → in_ready = 1 on the following cycle, not the same cycle.
- **Back-pressure.** Hold res_ready = 0 with 2 completed responses → res_data is held stable, the second unit sees resp_ready = 0, and no result is lost or duplicated after res_ready = 1.
- **Flush.** Assert flush with 3 in flight and out_v = 1 → next cycle res_valid = 0 and count = 0. A fresh issue after the flush returns as the first result.
- **Out-of-range unit index and wrap.** With NUM_UNITS = 3, in_unit = 3 → routed to unit 0 (req_valid = 3'b001). Run 10 back-to-back single-cycle instructions → pointers wrap correctly and all 10 results return in order.
